sync_uart_tx: RTL
=================

SYNC_UART_TX -- requirements
Module: sync_uart_tx

Interface
REQ-001 Parameter BYTE_SIZE, default 8: bits per payload byte.
REQ-002 Parameter MAX_MSG_LEN, default (1 << BYTE_SIZE) - 1: maximum encodable length value.
REQ-003 Parameter IN_DATA_SIZE, default $clog2(MAX_MSG_LEN) * BYTE_SIZE: payload bus width, 64 at defaults, so at most 8 bytes.
REQ-004 Port CLK, input, 1: single clock; all logic SHALL be rising-edge.
REQ-005 Port RST, input, 1: reset, asynchronous and active-high.
REQ-006 Port baud_en, input, 1: one-cycle bit-rate strobe; each line bit SHALL last one baud_en period.
REQ-007 Port i_valid, input, 1: frame request.
REQ-008 Port o_ready, output, 1: high only in IDLE.
REQ-009 Port i_opt, input, BYTE_SIZE: option byte.
REQ-010 Port i_len, input, BYTE_SIZE: payload byte count.
REQ-011 Port i_data, input, IN_DATA_SIZE: payload; the first byte sent is i_data[i_len*8-1 -: 8] and the last byte sent is i_data[7:0].
REQ-012 Port o_bit, output, 1: serial line, idle high.
REQ-013 Port o_busy, output, 1: high whenever state != IDLE.
REQ-014 Port o_done, output, 1: one-cycle pulse when the final CRC stop bit completes.
REQ-015 Port o_err, output, 1: one-cycle pulse when a request is rejected.

Function
REQ-016 A request SHALL be accepted on a cycle with i_valid && o_ready; i_opt, i_len and i_data SHALL be latched on that cycle, and later input changes SHALL have no effect.
REQ-017 If i_len > IN_DATA_SIZE/BYTE_SIZE at acceptance, the block SHALL pulse o_err the next cycle, stay in IDLE and transmit nothing.
REQ-018 States SHALL be IDLE -> INIT -> OPT -> LEN -> DATA -> CSM -> IDLE; LEN SHALL go directly to CSM when the latched length is 0.
REQ-019 o_bit and all bit or byte counters SHALL change only on CLK edges where baud_en=1.
REQ-020 The first bit SHALL be driven on the first baud_en after acceptance.
REQ-021 INIT SHALL send the 7-bit pattern 7'h7e MSB-first (1,1,1,1,1,1,0), with no start or stop bit.
REQ-022 Every byte after INIT SHALL be sent as: start bit 0, BYTE_SIZE data bits LSB-first, stop bit 1.
REQ-023 The opt byte SHALL be sent first, then the len byte, then i_len payload bytes, then 4 CRC bytes.
REQ-024 CRC-32 SHALL use polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection and no final XOR, bit-serial MSB-in.
REQ-025 CRC input SHALL be the data bits only (not start or stop bits) of the opt, len and payload bytes, in line order.
REQ-026 The CRC register SHALL reset to init on acceptance.
REQ-027 The CRC SHALL be frozen at the end of the last payload stop bit, or at the end of the LEN stop bit when length is 0.
REQ-028 The CRC SHALL be sent most-significant byte first, each byte framed per REQ-022.
REQ-029 o_done SHALL pulse on the cycle the last CRC stop bit period ends, and the state SHALL return to IDLE on the same edge.
REQ-030 The next request SHALL be accepted no earlier than the following cycle.
REQ-031 Total line bits per frame SHALL be 7 + 10*(6 + len).
REQ-032 i_valid while busy SHALL be ignored and never queued.
REQ-033 baud_en held low SHALL freeze all state, counters and o_bit indefinitely.
REQ-034 len = 8 SHALL be the maximum legal length and SHALL be transmitted with no overflow.

Reset
REQ-035 While RST is high, the block SHALL be in IDLE with o_bit=1, o_ready=1, o_busy=0, o_done=0 and o_err=0, and all counters and the CRC at zero or init.
REQ-036 RST asserted mid-frame SHALL force o_bit=1 immediately, without waiting for a clock edge.
REQ-037 After RST deasserts, the block SHALL accept a new request on the first i_valid.

Verification
REQ-038 Scenario: opt=0xA5, len=0, baud_en every 4th cycle -> 67 line bits; first 7 bits 1111110; opt byte bits 0,1,0,1,0,0,1,0,1,1; CRC matches the model over {A5,00}; o_done once.
REQ-039 Scenario: opt=0x01, len=2, i_data[15:0]=0x1234 -> bytes on line 01,02,12,34, then CRC MSB-first; 87 bits; a loopback into sync_uart_rx gives o_valid=1, o_len=2, o_data=0x1234.
REQ-040 Scenario: len=9 -> o_err pulse 1 cycle after accept, o_bit stays 1, o_ready stays 1.
REQ-041 Scenario: len=8, data 0x0102030405060708 -> 147 bits; payload order 01..08.
REQ-042 Scenario: i_valid toggled and inputs changed during a frame, and baud_en held low for 100 cycles mid-byte -> line output identical to the undisturbed frame, with only the stall added.
REQ-043 Scenario: RST pulse during DATA -> o_bit=1 asynchronously, o_busy=0; a new len=1 frame after reset is correct and CRC-valid.

Source files
------------

// File: rtl/sync_uart_tx_if.sv
// sync_uart_tx_if -- request/line bundle for the synchronous UART framer.
//   baud_en : bit-rate strobe, one CLK cycle wide
//   i_valid : frame request; i_opt / i_len / i_data are sampled with it
//   o_ready : framer idle and able to take a request
//   o_bit   : serial line, idle high
//   o_busy  : frame in progress
//   o_done  : one-cycle pulse when the frame's last stop bit ends
//   o_err   : one-cycle pulse when a request is rejected (length too big)
// The master modport belongs to the requester, the slave modport to the framer.
interface sync_uart_tx_if #(
  parameter int BYTE_SIZE    = 8,
  parameter int MAX_MSG_LEN  = (1 << BYTE_SIZE) - 1,
  parameter int IN_DATA_SIZE = $clog2(MAX_MSG_LEN) * BYTE_SIZE
);
  logic                    baud_en;
  logic                    i_valid;
  logic                    o_ready;
  logic [BYTE_SIZE-1:0]    i_opt;
  logic [BYTE_SIZE-1:0]    i_len;
  logic [IN_DATA_SIZE-1:0] i_data;
  logic                    o_bit;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_err;

  modport master (
    output baud_en, i_valid, i_opt, i_len, i_data,
    input  o_ready, o_bit, o_busy, o_done, o_err
  );

  modport slave (
    input  baud_en, i_valid, i_opt, i_len, i_data,
    output o_ready, o_bit, o_busy, o_done, o_err
  );
endinterface

// File: rtl/sync_uart_tx.sv
// sync_uart_tx -- serialises one frame per accepted request:
//   7-bit preamble 1111110, then opt, len, len payload bytes and a 4-byte
//   CRC-32 (poly 04C11DB7, init FFFFFFFF, MSB-in, no reflection/final XOR).
//   Every byte after the preamble is framed start(0), data LSB-first, stop(1).
// Ports:
//   CLK : rising-edge clock
//   RST : asynchronous, active-high reset; forces the line high at once
//   bus : sync_uart_tx_if.slave (request handshake, payload, line, status)
module sync_uart_tx #(
  parameter int BYTE_SIZE    = 8,
  parameter int MAX_MSG_LEN  = (1 << BYTE_SIZE) - 1,
  parameter int IN_DATA_SIZE = $clog2(MAX_MSG_LEN) * BYTE_SIZE
) (
  input logic           CLK,
  input logic           RST,
  sync_uart_tx_if.slave bus
);

  localparam int                   MAX_BYTES = IN_DATA_SIZE / BYTE_SIZE;
  localparam int                   IDX_W     = $clog2(BYTE_SIZE + 3);
  localparam logic [IDX_W-1:0]     STOP_IDX  = IDX_W'(BYTE_SIZE + 1);
  // One index past the stop bit: the last CRC stop bit is still on the line
  // while the counter sits here, and the following strobe ends the frame.
  localparam logic [IDX_W-1:0]     TAIL_IDX  = IDX_W'(BYTE_SIZE + 2);
  localparam logic [IDX_W-1:0]     INIT_LAST = IDX_W'(6);
  localparam logic [6:0]           INIT_PAT  = 7'h7e;
  localparam logic [31:0]          CRC_POLY  = 32'h04C1_1DB7;
  localparam logic [31:0]          CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [BYTE_SIZE-1:0] MAX_LEN   = BYTE_SIZE'(MAX_BYTES);
  localparam logic [BYTE_SIZE-1:0] CRC_LAST  = BYTE_SIZE'(3);

  typedef enum logic [2:0] {IDLE, INIT, OPT, LEN, DATA, CSM} state_t;

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b);
    crc_step = {crc[30:0], 1'b0} ^ ((crc[31] ^ b) ? CRC_POLY : 32'h0);
  endfunction

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        bit_idx, bit_nx;
  logic [BYTE_SIZE-1:0]    byte_cnt, byte_nx;
  logic [31:0]             crc_r;
  logic [BYTE_SIZE-1:0]    opt_r, len_r;
  logic [IN_DATA_SIZE-1:0] data_r;
  logic                    o_bit_r, done_r, err_r;

  logic                    accept, err_nx, done_nx, crc_en, data_shift, line_bit;
  logic [BYTE_SIZE-1:0]    cur_byte;
  logic                    is_stop, is_data_bit, data_bit, frame_bit, init_bit;

  // Byte currently being framed; payload is pre-aligned so its next byte
  // always sits in the top lane of data_r.
  always_comb begin
    case (state)
      OPT:     cur_byte = opt_r;
      LEN:     cur_byte = len_r;
      DATA:    cur_byte = data_r[IN_DATA_SIZE-1 -: BYTE_SIZE];
      default: cur_byte = BYTE_SIZE'(crc_r >> {CRC_LAST - byte_cnt, 3'b000});
    endcase
  end

  // bit_idx within a byte: 0 = start, 1..BYTE_SIZE = data LSB-first, then stop.
  assign is_stop     = (bit_idx == STOP_IDX);
  assign is_data_bit = (bit_idx != '0) && (bit_idx < STOP_IDX);
  assign data_bit    = |(cur_byte & (BYTE_SIZE'(1) << (bit_idx - 1'b1)));
  assign frame_bit   = is_stop | (is_data_bit & data_bit);
  assign init_bit    = |(INIT_PAT & (7'h40 >> bit_idx));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Counters advance only on strobe cycles; acceptance alone just leaves
  // IDLE so the first preamble bit appears on the next strobe.
  always_comb begin
    state_nx   = state;
    bit_nx     = bit_idx;
    byte_nx    = byte_cnt;
    line_bit   = 1'b1;
    accept     = 1'b0;
    err_nx     = 1'b0;
    done_nx    = 1'b0;
    crc_en     = 1'b0;
    data_shift = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          if (bus.i_len > MAX_LEN) begin
            err_nx = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = INIT;
          end
        end
      end
      INIT: begin
        if (bus.baud_en) begin
          line_bit = init_bit;
          if (bit_idx == INIT_LAST) begin
            state_nx = OPT;
            bit_nx   = '0;
          end else begin
            bit_nx = bit_idx + 1'b1;
          end
        end
      end
      OPT, LEN, DATA: begin
        if (bus.baud_en) begin
          line_bit = frame_bit;
          crc_en   = is_data_bit;
          if (is_stop) begin
            bit_nx = '0;
            case (state)
              OPT:     state_nx = LEN;
              LEN:     state_nx = (len_r == '0) ? CSM : DATA;
              default: begin
                data_shift = 1'b1;
                if (byte_cnt == len_r - 1'b1) begin
                  state_nx = CSM;
                  byte_nx  = '0;
                end else begin
                  byte_nx = byte_cnt + 1'b1;
                end
              end
            endcase
          end else begin
            bit_nx = bit_idx + 1'b1;
          end
        end
      end
      CSM: begin
        if (bus.baud_en) begin
          if (bit_idx == TAIL_IDX) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            bit_nx   = '0;
            byte_nx  = '0;
          end else begin
            line_bit = frame_bit;
            if (is_stop && byte_cnt != CRC_LAST) begin
              bit_nx  = '0;
              byte_nx = byte_cnt + 1'b1;
            end else begin
              bit_nx = bit_idx + 1'b1;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_idx  <= '0;
      byte_cnt <= '0;
      crc_r    <= CRC_INIT;
      o_bit_r  <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      bit_idx  <= bit_nx;
      byte_cnt <= byte_nx;
      done_r   <= done_nx;
      err_r    <= err_nx;
      if (accept)      crc_r <= CRC_INIT;
      else if (crc_en) crc_r <= crc_step(crc_r, data_bit);
      if (bus.baud_en) o_bit_r <= line_bit;
    end
  end

  // Request fields; left-justify the payload so its first byte is on top.
  always_ff @(posedge CLK) begin
    if (accept) begin
      opt_r  <= bus.i_opt;
      len_r  <= bus.i_len;
      data_r <= bus.i_data << (int'(MAX_LEN - bus.i_len) * BYTE_SIZE);
    end else if (data_shift) begin
      data_r <= data_r << BYTE_SIZE;
    end
  end

  assign bus.o_ready = (state == IDLE);
  assign bus.o_busy  = (state != IDLE);
  assign bus.o_bit   = o_bit_r;
  assign bus.o_done  = done_r;
  assign bus.o_err   = err_r;

endmodule
